// File: rtl/phivers_link_pkg.sv
// phivers_link_pkg: shared flit type and framing states for the Phivers link sink.
package phivers_link_pkg;
  localparam int FLIT_W = 32;
  typedef struct packed {
    logic              eop;
    logic [FLIT_W-1:0] data;
  } flit_t;
  typedef enum logic [1:0] {IDLE, BODY, CORRUPT} frame_state_t;
endpackage

// File: rtl/phivers_link_fifo.sv
// phivers_link_fifo: power-of-two flit FIFO with wrap-bit pointers and combinational head.
module phivers_link_fifo
  import phivers_link_pkg::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push,
  input  logic  pop,
  input  flit_t din,
  output logic  full,
  output logic  empty,
  output flit_t head
);
  localparam int AW = $clog2(BUFFER_SIZE);
  flit_t mem [BUFFER_SIZE];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign head  = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk_i)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/phivers_link_sink.sv
// phivers_link_sink: credit-based link receiver with drop detection, packet framing and statistics.
module phivers_link_sink
  import phivers_link_pkg::*;
#(
  parameter int          BUFFER_SIZE = 8,
  parameter logic [15:0] ADDRESS     = 16'b0,
  parameter string       PORT        = "",
  parameter int          CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic              cr_rx_o,
  input  logic              eop_rx_i,
  input  logic [FLIT_W-1:0] data_rx_i,
  output logic              tx_o,
  input  logic              cr_tx_i,
  output logic              eop_tx_o,
  output logic [FLIT_W-1:0] data_tx_o,
  output logic              drop_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic [CNT_W-1:0]  pkt_cnt_o
);
  logic full, empty, push, pop, violation;
  flit_t din, head;
  frame_state_t state;
  assign cr_rx_o   = !full;
  assign push      = rx_i && !full;
  assign violation = rx_i && full;
  assign tx_o      = !empty;
  assign pop       = tx_o && cr_tx_i;
  assign eop_tx_o  = !empty && head.eop;
  assign data_tx_o = empty ? '0 : head.data;
  assign din       = '{eop: eop_rx_i, data: data_rx_i};
  phivers_link_fifo #(.BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push(push),
    .pop(pop),
    .din(din),
    .full(full),
    .empty(empty),
    .head(head)
  );
  // push and violation are mutually exclusive, so only one branch moves the FSM per cycle
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state      <= IDLE;
      drop_o     <= 1'b0;
      err_o      <= 1'b0;
      drop_cnt_o <= '0;
      pkt_cnt_o  <= '0;
    end else begin
      drop_o <= violation;
      if (violation) begin
        err_o <= 1'b1;
        if (~&drop_cnt_o) drop_cnt_o <= drop_cnt_o + 1'b1;
        if (state == BODY) state <= CORRUPT;
      end
      if (push) begin
        state <= eop_rx_i ? IDLE : (state == CORRUPT ? CORRUPT : BODY);
        if (eop_rx_i && state != CORRUPT && ~&pkt_cnt_o) pkt_cnt_o <= pkt_cnt_o + 1'b1;
      end
    end
`ifndef SYNTHESIS
  always_ff @(posedge clk_i)
    if (violation) $display("%m: router %h port %s dropped flit %h", ADDRESS, PORT, data_rx_i);
`endif
endmodule
